// File: rtl/viterbi_frame_sequencer.sv
// Frame-level sequencer for a K=3 hard-decision Viterbi decoder (2-bit state, parity pair/step).
// Accepts payload symbol pairs over valid/ready, issues one symbol per cycle to the decoder,
// fills idle cycles with bubbles, appends two zero-input tail symbols, and assembles the
// decoder's output bits into a frame word with an error flag.
//
// Ports:
//   CLK, RST_N            clock, synchronous active-low reset
//   sym_valid/sym_ready   payload symbol handshake
//   sym_parities          received parity pair
//   sym_erase             per-bit erasure flags (erased bit is not driven to the decoder)
//   dec_parities          registered symbol to the decoder, 2'bzz for a bubble
//   dec_out               decoder's registered output bit
//   frm_valid/frm_ready   decoded frame handshake
//   frm_bits              decoded bits, bit i = payload symbol i
//   frm_err               illegal symbol or decoder disagreement seen in the frame
//   busy                  high whenever the sequencer is not in IDLE
module viterbi_frame_sequencer #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned IDX_W     = 6
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 sym_valid,
  output logic                 sym_ready,
  input  logic [1:0]           sym_parities,
  input  logic [1:0]           sym_erase,
  output logic [1:0]           dec_parities,
  input  logic                 dec_out,
  output logic                 frm_valid,
  input  logic                 frm_ready,
  output logic [FRAME_LEN-1:0] frm_bits,
  output logic                 frm_err,
  output logic                 busy
);

  localparam logic [IDX_W-1:0] FrameLenW = IDX_W'(FRAME_LEN);
  localparam logic [IDX_W-1:0] IdxOne    = IDX_W'(1);

  typedef enum logic [2:0] {StResync, StIdle, StFeed, StTail, StDrain, StDone} state_e;

  // Travels alongside an issued symbol so its decoded bit can be filed two edges later.
  typedef struct packed {
    logic             vld;
    logic             tail;
    logic             illegal;
    logic             exp_bit;
    logic [IDX_W-1:0] idx;
  } tag_t;

  state_e               state_q, state_d;
  logic [1:0]           ph_q, ph_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           par_q, par_d;
  logic [1:0]           par_oe_q, par_oe_d;
  tag_t                 tag0_q, tag0_d, tag1_q;
  logic [FRAME_LEN-1:0] bits_q, bits_d;
  logic                 err_q, err_d;
  logic [1:0]           shadow_q, shadow_d;

  logic [1:0] cw0;
  logic       sym_bit;
  logic       sym_illegal;

  // Tristate drive: an erased bit or a bubble leaves the decoder input floating.
  assign dec_parities[0] = par_oe_q[0] ? par_q[0] : 1'bz;
  assign dec_parities[1] = par_oe_q[1] ? par_q[1] : 1'bz;

  assign frm_valid = (state_q == StDone);
  assign frm_bits  = bits_q;
  assign frm_err   = err_q;
  assign busy      = (state_q != StIdle);

  // Input-0 codeword of the shadow state: 00->00, 01->10, 11->01, 10->11.
  assign cw0 = {shadow_q[1] ^ shadow_q[0], shadow_q[1]};

  // Hard decision of the incoming symbol against the shadow state.
  always_comb begin
    sym_bit     = 1'b0;
    sym_illegal = 1'b0;
    case (sym_erase)
      2'b00: begin
        if (sym_parities == cw0) begin
          sym_bit = 1'b0;
        end else if (sym_parities == ~cw0) begin
          sym_bit = 1'b1;
        end else begin
          sym_illegal = 1'b1;
        end
      end
      2'b10:   sym_bit = sym_parities[0] ^ cw0[0];
      2'b01:   sym_bit = sym_parities[1] ^ cw0[1];
      default: sym_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    par_d     = '0;
    par_oe_d  = '0;
    tag0_d    = '0;
    bits_d    = bits_q;
    err_d     = err_q;
    sym_ready = 1'b0;

    // Capture the decoder bit for the symbol issued two edges ago.
    if (tag1_q.vld) begin
      if (!tag1_q.tail) begin
        for (int i = 0; i < int'(FRAME_LEN); i++) begin
          if (tag1_q.idx == IDX_W'(i)) begin
            bits_d[i] = dec_out;
          end
        end
      end
      if (tag1_q.illegal || (dec_out != tag1_q.exp_bit)) begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      StResync: begin
        // Two untagged tail symbols flush the decoder, then two bubble cycles.
        if (!ph_q[1]) begin
          par_d    = cw0;
          par_oe_d = 2'b11;
          shadow_d = {shadow_q[0], 1'b0};
        end
        ph_d = ph_q + 2'd1;
        if (ph_q == 2'd3) begin
          state_d = StIdle;
          ph_d    = '0;
        end
      end
      StIdle, StFeed: begin
        sym_ready = (cnt_q < FrameLenW);
        if (sym_valid && sym_ready) begin
          par_d          = sym_parities & ~sym_erase;
          par_oe_d       = ~sym_erase;
          tag0_d.vld     = 1'b1;
          tag0_d.illegal = sym_illegal;
          tag0_d.exp_bit = sym_bit;
          tag0_d.idx     = cnt_q;
          if (!sym_illegal) begin
            shadow_d = {shadow_q[0], sym_bit};
          end
          cnt_d   = cnt_q + IdxOne;
          state_d = ((cnt_q + IdxOne) == FrameLenW) ? StTail : StFeed;
        end
      end
      StTail: begin
        par_d          = cw0;
        par_oe_d       = 2'b11;
        tag0_d.vld     = 1'b1;
        tag0_d.tail    = 1'b1;
        shadow_d       = {shadow_q[0], 1'b0};
        ph_d           = ph_q + 2'd1;
        if (ph_q[0]) begin
          state_d = StDrain;
          ph_d    = '0;
        end
      end
      StDrain: begin
        ph_d = ph_q + 2'd1;
        if (ph_q[0]) begin
          state_d = StDone;
          ph_d    = '0;
        end
      end
      StDone: begin
        if (frm_ready) begin
          bits_d  = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StResync;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= StResync;
      ph_q     <= '0;
      cnt_q    <= '0;
      par_q    <= '0;
      par_oe_q <= '0;
      tag0_q   <= '0;
      tag1_q   <= '0;
      bits_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      cnt_q    <= cnt_d;
      par_q    <= par_d;
      par_oe_q <= par_oe_d;
      tag0_q   <= tag0_d;
      tag1_q   <= tag0_q;
      bits_q   <= bits_d;
      err_q    <= err_d;
    end
  end

  // The decoder has no reset, so its mirror keeps its value through reset; RESYNC uses it.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      shadow_q <= shadow_d;
    end
  end

endmodule
